// File: rtl/rce_parity_accumulator.sv
// -----------------------------------------------------------------------------
// rce_parity_accumulator
//
// Serial QC-circulant parity accumulator, placed directly after the
// Function_generator stage. For each of the N_BLK = 2**ADR_W circulant blocks:
//   - it addresses the generator;
//   - it latches the returned first row;
//   - it XORs the current cyclic rotation of that row into a parity accumulator
//     for every accepted message bit that is 1.
// After the last block the parity word is offered with a valid/ready handshake.
//
// Ports
//   clk         in   1      system clock, rising edge
//   rst         in   1      asynchronous active-high reset
//   start       in   1      1-cycle pulse, begins a codeword (IDLE only)
//   fg_adrs     out  ADR_W  registered row address to the generator
//   fg_f        in   K_N    circulant first row for fg_adrs (combinational)
//   in_valid    in   1      message bit valid
//   in_bit      in   1      message bit, block-major, bit 0 of block 0 first
//   in_ready    out  1      bit accepted this cycle when in_valid is high
//   out_valid   out  1      parity_out complete
//   out_ready   in   1      consumer takes parity_out
//   parity_out  out  K_N    accumulated parity word
//   busy        out  1      high in any state other than IDLE
// -----------------------------------------------------------------------------
module rce_parity_accumulator #(
  parameter int K_N   = 256,
  parameter int ADR_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [ADR_W-1:0] fg_adrs,
  input  logic [K_N-1:0]   fg_f,
  input  logic             in_valid,
  input  logic             in_bit,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [K_N-1:0]   parity_out,
  output logic             busy
);

  localparam int CNT_W = $clog2(K_N);
  localparam int N_BLK = 2 ** ADR_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] bit_cnt;
  logic [K_N-1:0]   acc;
  logic [K_N-1:0]   row;
  logic             xfer;
  logic             blk_end;
  logic             last_blk;

  // Cyclic rotate-left by one position.
  function automatic logic [K_N-1:0] rotl1(input logic [K_N-1:0] v);
    return {v[K_N-2:0], v[K_N-1]};
  endfunction

  // Conditionally XOR the current circulant rotation into the accumulator.
  function automatic logic [K_N-1:0] acc_step(input logic [K_N-1:0] a,
                                              input logic [K_N-1:0] r,
                                              input logic           b);
    return b ? (a ^ r) : a;
  endfunction

  always_comb begin
    xfer     = (state == RUN) && in_valid;
    blk_end  = xfer && (bit_cnt == CNT_W'(K_N - 1));
    last_blk = (fg_adrs == ADR_W'(N_BLK - 1));
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_nxt  = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = (state != IDLE);
    parity_out = acc;
    case (state)
      IDLE: if (start) state_nxt = LOAD;
      LOAD: state_nxt = RUN;
      RUN: begin
        in_ready = 1'b1;
        if (blk_end) state_nxt = last_blk ? DONE : LOAD;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Stage: row latch (LOAD) and per-bit accumulate/rotate (RUN).
  // The address only advances on a non-final block end, so it never wraps
  // within a codeword and the next LOAD sees a settled fg_f.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fg_adrs <= '0;
      acc     <= '0;
      row     <= '0;
      bit_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          fg_adrs <= '0;
          acc     <= '0;
        end
        LOAD: begin
          row     <= fg_f;
          bit_cnt <= '0;
        end
        RUN: if (xfer) begin
          acc     <= acc_step(acc, row, in_bit);
          row     <= rotl1(row);
          bit_cnt <= bit_cnt + 1'b1;
          if (blk_end && !last_blk) fg_adrs <= fg_adrs + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rce_parity_accumulator.sv
module tb_rce_parity_accumulator;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   fg_adrs;
  logic [255:0] fg_f;
  logic         in_valid;
  logic         in_bit;
  logic         in_ready;
  logic         out_valid;
  logic         out_ready;
  logic [255:0] parity_out;
  logic         busy;

  logic         stub_shift = 1'b0;
  logic [255:0] one = 256'h1;
  int           cyc = 0;
  int           total = 0;
  int           passed = 0;
  int           low_cnt [4];
  int           adrs_err;

  rce_parity_accumulator #(.K_N(256), .ADR_W(2)) dut (
    .clk(clk), .rst(rst), .start(start), .fg_adrs(fg_adrs), .fg_f(fg_f),
    .in_valid(in_valid), .in_bit(in_bit), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .parity_out(parity_out),
    .busy(busy)
  );

  // Stub generator: constant 1, or 1 << address.
  assign fg_f = stub_shift ? (one << fg_adrs) : one;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [255:0] model(input logic [1023:0] m, input bit shift);
    logic [255:0] a, f;
    a = '0;
    for (int b = 0; b < 4; b++) begin
      f = shift ? (256'h1 << b) : 256'h1;
      for (int j = 0; j < 256; j++)
        if (m[b*256+j]) a ^= (f << j) | (f >> (256 - j));
    end
    return a;
  endfunction

  // Runs one codeword. abort_at >= 0 asserts reset once that many bits are in.
  task automatic run(input logic [1023:0] m, input bit gaps, input bit start_mid,
                     input int abort_at, output logic [255:0] res, output int lat);
    int  idx, t0, seen;
    bit  vld, mid_done;
    idx = 0; mid_done = 0; res = '0; lat = -1; adrs_err = 0;
    for (int i = 0; i < 4; i++) low_cnt[i] = 0;
    @(negedge clk);
    start = 1'b1; in_valid = 1'b0; t0 = cyc;
    for (int n = 0; n < 5000; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (out_valid) begin
        in_valid = 1'b0;
        res = parity_out;
        lat = cyc - t0;
        return;
      end
      if (!in_ready && idx > 0 && idx < 1024) low_cnt[idx/256]++;
      if (in_ready && (idx % 256) == 0 && idx < 1024 && fg_adrs != 2'(idx/256)) adrs_err++;
      if (abort_at >= 0 && idx == abort_at && in_ready) begin
        #2 rst = 1'b1;
        #1;
        chk("rst_in_ready", 256'(in_ready), 256'h0);
        chk("rst_busy", 256'(busy), 256'h0);
        chk("rst_fg_adrs", 256'(fg_adrs), 256'h0);
        chk("rst_parity", parity_out, 256'h0);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (1100) begin
          @(negedge clk);
          if (out_valid) seen++;
        end
        chk("abort_no_out_valid", 256'(seen), 256'h0);
        return;
      end
      if (start_mid && !mid_done && idx == 100) begin
        start = 1'b1;
        mid_done = 1;
      end
      vld = (idx < 1024) && (!gaps || ($urandom_range(0, 1) == 1));
      in_valid = vld;
      in_bit = vld ? m[idx] : 1'b0;
      if (vld && in_ready) idx++;
    end
    total++;
    $error("FAIL timeout: got no out_valid expected out_valid within 5000 cycles");
  endtask

  task automatic ack();
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("ack_out_valid", 256'(out_valid), 256'h0);
  endtask

  initial begin
    logic [1023:0] m;
    logic [255:0]  r1, r2, exp;
    int            lat;

    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_bit = 1'b0; out_ready = 1'b0;
    #1;
    chk("reset_busy", 256'(busy), 256'h0);
    chk("reset_in_ready", 256'(in_ready), 256'h0);
    chk("reset_out_valid", 256'(out_valid), 256'h0);
    chk("reset_fg_adrs", 256'(fg_adrs), 256'h0);
    chk("reset_parity", parity_out, 256'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // 1. reset during RUN at bit 300
    m = '0; m[10] = 1'b1;
    run(m, 0, 0, 300, r1, lat);

    // 2. single set bits
    m = '0; m[0] = 1'b1;
    run(m, 0, 0, -1, r1, lat);
    chk("bit0_blk0", r1, 256'h1);
    ack();
    m = '0; m[2*256+5] = 1'b1;
    run(m, 0, 0, -1, r1, lat);
    chk("bit5_blk2", r1, 256'h20);
    ack();

    // 3. block 0 all ones
    m = '0; m[255:0] = '1;
    run(m, 0, 0, -1, r1, lat);
    chk("blk0_all_ones", r1, {256{1'b1}});
    ack();

    // 4. address-dependent stub
    stub_shift = 1'b1;
    m = '0; m[0] = 1'b1; m[256] = 1'b1; m[512] = 1'b1; m[768] = 1'b1;
    run(m, 0, 0, -1, r1, lat);
    chk("shift_stub_parity", r1, 256'hF);
    chk("adrs_steps", 256'(adrs_err), 256'h0);
    chk("no_gap_in_blk0", 256'(low_cnt[0]), 256'h0);
    chk("gap_after_256", 256'(low_cnt[1]), 256'h1);
    chk("gap_after_512", 256'(low_cnt[2]), 256'h1);
    chk("gap_after_768", 256'(low_cnt[3]), 256'h1);
    ack();

    // 5. random message, gapped and gap-free
    stub_shift = 1'b0;
    for (int i = 0; i < 32; i++) m[i*32 +: 32] = $urandom;
    exp = model(m, 0);
    run(m, 1, 0, -1, r1, lat);
    chk("random_gapped", r1, exp);
    chk("gapped_boundary_low", 256'(low_cnt[2]), 256'h1);
    ack();
    run(m, 0, 0, -1, r2, lat);
    chk("random_gap_free", r2, exp);
    chk("latency", 256'(lat), 256'd1029);
    ack();

    // 6. start in RUN ignored; DONE held with out_ready low
    m = '0; m[2*256+5] = 1'b1; m[3] = 1'b1;
    run(m, 0, 1, -1, r1, lat);
    chk("start_in_run_ignored", r1, 256'h28);
    for (int i = 0; i < 10; i++) begin
      start = (i == 4);
      @(negedge clk);
      chk("done_hold_parity", parity_out, 256'h28);
      chk("done_hold_valid", 256'(out_valid), 256'h1);
    end
    start = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0; out_ready = 1'b0;
    chk("after_ack_valid", 256'(out_valid), 256'h0);
    chk("after_ack_busy", 256'(busy), 256'h0);
    chk("after_ack_parity", parity_out, 256'h28);
    @(negedge clk);
    chk("start_at_ack_ignored", 256'(busy), 256'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
